lc3_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the LC-3 execute model. It owns the fetch PC, issues single-word reads to instruction memory over a req/ack handshake, and buffers fetched words with their incremented PC. It presents them to the execute stage over a valid/ready interface. Redirects from the execute stage (BR/JMP/JSR targets) flush the buffer and restart fetch at the new address.

---
 rtl/lc3_fetch_unit_if.sv | 48 ++++
 rtl/lc3_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_lc3_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_fetch_unit_if.sv
// Bundle of the fetch unit's two handshakes: the instruction-memory
// req/ack read port and the valid/ready instruction port towards execute,
// plus the redirect pulse coming back from execute.
interface lc3_fetch_unit_if;
    // Instruction memory read port
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    // Instruction delivery towards the execute stage
    logic [15:0] ir;
    logic [15:0] ir_npc;
    logic        ir_valid;
    logic        ir_ready;

    // Control-flow change reported by the execute stage
    logic        redirect;
    logic [15:0] redirect_pc;

    // The fetch unit itself
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output ir,
        output ir_npc,
        output ir_valid,
        input  ir_ready,
        input  redirect,
        input  redirect_pc
    );

    // Its surroundings: instruction memory plus execute stage
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  ir,
        input  ir_npc,
        input  ir_valid,
        output ir_ready,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch stage. Owns the fetch PC, issues one-word reads to
// instruction memory, queues returned words together with their incremented
// PC in a small circular FIFO and hands them to execute over valid/ready.
// A redirect flushes the FIFO and restarts fetching at the new address; a
// read already in flight is allowed to complete and its data is thrown away.
module lc3_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h3000,
    parameter int          BUF_DEPTH = 2
) (
    input logic               clk,
    input logic               rst_n,
    lc3_fetch_unit_if.master  fetch_if
);

    // Fetch controller states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // Storage is sized for the largest legal depth; only the first
    // BUF_DEPTH slots are ever addressed.
    localparam int         MAX_DEPTH = 4;
    localparam logic [2:0] DEPTH     = 3'(BUF_DEPTH);
    localparam logic [1:0] LAST_PTR  = 2'(BUF_DEPTH - 1);

    logic [1:0]  r_state;
    logic [15:0] r_fpc;
    logic [15:0] r_pend_pc;
    logic        r_mem_req;
    logic [15:0] r_mem_addr;

    logic [15:0] r_buf_word [0:MAX_DEPTH-1];
    logic [15:0] r_buf_npc  [0:MAX_DEPTH-1];
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [2:0]  r_count;

    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic        w_flush;
    logic        w_has_room;
    logic [15:0] w_fpc_inc;

    // Circular pointer advance that wraps at the configured depth
    function automatic logic [1:0] nextPtr(input logic [1:0] ptr);
        nextPtr = (ptr == LAST_PTR) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Handshake qualifiers shared by the controller and the FIFO
    always_comb begin
        w_valid    = (r_count != 3'd0);
        w_pop      = w_valid & fetch_if.ir_ready;
        w_push     = (r_state == ST_REQ) & fetch_if.mem_ack & ~fetch_if.redirect;
        w_flush    = fetch_if.redirect;
        w_has_room = (r_count < DEPTH);
        w_fpc_inc  = r_fpc + 16'd1;
    end

    // Fetch controller: issues a request from IDLE when the FIFO has room,
    // waits for ack in REQ, and in DISCARD waits out a request whose data
    // became stale because of a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fpc      <= RESET_PC;
            r_pend_pc  <= 16'h0000;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (fetch_if.redirect) begin
                        r_fpc <= fetch_if.redirect_pc;
                    end else if (w_has_room) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fpc;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (fetch_if.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                        r_fpc     <= fetch_if.redirect ? fetch_if.redirect_pc : w_fpc_inc;
                    end else if (fetch_if.redirect) begin
                        r_pend_pc <= fetch_if.redirect_pc;
                        r_state   <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (fetch_if.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                        r_fpc     <= fetch_if.redirect ? fetch_if.redirect_pc : r_pend_pc;
                    end else if (fetch_if.redirect) begin
                        r_pend_pc <= fetch_if.redirect_pc;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO occupancy and pointers; a redirect empties the queue after any
    // same-cycle pop has already handed its instruction to execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
        end else if (w_flush) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_tail <= nextPtr(r_tail);
            end
            if (w_pop) begin
                r_head <= nextPtr(r_head);
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    // FIFO payload: the fetched word and the address following it
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_word[r_tail] <= fetch_if.mem_rdata;
            r_buf_npc[r_tail]  <= w_fpc_inc;
        end
    end

    assign fetch_if.mem_req  = r_mem_req;
    assign fetch_if.mem_addr = r_mem_addr;
    assign fetch_if.ir_valid = w_valid;
    assign fetch_if.ir       = w_valid ? r_buf_word[r_head] : 16'h0000;
    assign fetch_if.ir_npc   = w_valid ? r_buf_npc[r_head]  : 16'h0000;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Self-checking bench for lc3_fetch_unit: directed scenarios with literal
// expectations plus a per-cycle comparison against a queue-based model.
module tb_lc3_fetch_unit;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    lc3_fetch_unit_if fif();

    lc3_fetch_unit #(
        .RESET_PC  (16'h3000),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetch_if (fif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory responder configuration
    int          reqAge = 0;
    int          ackDelay = 0;
    bit          ackEnable = 1'b1;
    bit          useFixed = 1'b0;
    logic [15:0] fixedWord = 16'h0000;

    // Model state: delivered-but-not-consumed instructions, the address the
    // next fresh request will use, and the single outstanding read.
    logic [31:0] mQ[$];
    logic [15:0] mNextPc;
    bit          mBusy;
    logic [15:0] mAddr;
    bit          mStale;
    logic [15:0] mStalePc;
    int          mHeld;

    // Model advance on every rising edge, driven only by the bench's inputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mQ.delete();
            mNextPc  = 16'h3000;
            mBusy    = 1'b0;
            mAddr    = 16'h0000;
            mStale   = 1'b0;
            mStalePc = 16'h0000;
        end else begin
            mHeld = mQ.size();
            if (mHeld != 0 && fif.ir_ready) begin
                void'(mQ.pop_front());
            end
            if (!mBusy) begin
                if (fif.redirect) begin
                    mQ.delete();
                    mNextPc = fif.redirect_pc;
                end else if (mHeld < DEPTH) begin
                    mBusy  = 1'b1;
                    mAddr  = mNextPc;
                    mStale = 1'b0;
                end
            end else if (fif.mem_ack) begin
                mBusy = 1'b0;
                if (fif.redirect) begin
                    mQ.delete();
                    mNextPc = fif.redirect_pc;
                end else if (mStale) begin
                    mNextPc = mStalePc;
                end else begin
                    mQ.push_back({fif.mem_rdata, mAddr + 16'd1});
                    mNextPc = mAddr + 16'd1;
                end
            end else if (fif.redirect) begin
                mQ.delete();
                mStale   = 1'b1;
                mStalePc = fif.redirect_pc;
            end
        end
    end

    task automatic checkLiteral(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    task automatic checkOutput();
        logic [15:0] expIr;
        logic [15:0] expNpc;
        expIr  = 16'h0000;
        expNpc = 16'h0000;
        if (mQ.size() != 0) begin
            expIr  = mQ[0][31:16];
            expNpc = mQ[0][15:0];
        end
        checkLiteral("model mem_req", {15'd0, fif.mem_req}, {15'd0, mBusy});
        if (mBusy) begin
            checkLiteral("model mem_addr", fif.mem_addr, mAddr);
        end
        checkLiteral("model ir_valid", {15'd0, fif.ir_valid}, {15'd0, (mQ.size() != 0)});
        checkLiteral("model ir", fif.ir, expIr);
        checkLiteral("model ir_npc", fif.ir_npc, expNpc);
    endtask

    // One clock cycle: compare at the falling edge, then let the memory
    // responder decide the ack for the coming rising edge.
    task automatic applyStimulus();
        @(negedge clk);
        if (rst_n) begin
            checkOutput();
        end
        if (rst_n && fif.mem_req) begin
            reqAge++;
            fif.mem_ack   = ackEnable && (reqAge > ackDelay);
            fif.mem_rdata = useFixed ? fixedWord : (fif.mem_addr ^ 16'h5A5A);
        end else begin
            reqAge      = 0;
            fif.mem_ack = 1'b0;
        end
    endtask

    // Asynchronous reset asserted between edges, reset values checked,
    // released on a falling edge.
    task automatic doReset();
        fif.redirect = 1'b0;
        fif.mem_ack  = 1'b0;
        fif.ir_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkLiteral("reset mem_req", {15'd0, fif.mem_req}, 16'h0000);
        checkLiteral("reset mem_addr", fif.mem_addr, 16'h0000);
        checkLiteral("reset ir_valid", {15'd0, fif.ir_valid}, 16'h0000);
        checkLiteral("reset ir", fif.ir, 16'h0000);
        checkLiteral("reset ir_npc", fif.ir_npc, 16'h0000);
        reqAge = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fif.mem_ack     = 1'b0;
        fif.mem_rdata   = 16'h0000;
        fif.ir_ready    = 1'b0;
        fif.redirect    = 1'b0;
        fif.redirect_pc = 16'h0000;

        // Scenario 1: one-cycle ack latency, fixed instruction word
        doReset();
        ackEnable = 1'b1; ackDelay = 1; useFixed = 1'b1; fixedWord = 16'h1261;
        fif.ir_ready = 1'b1;
        applyStimulus();
        checkLiteral("s1 first req", {15'd0, fif.mem_req}, 16'h0001);
        checkLiteral("s1 first addr", fif.mem_addr, 16'h3000);
        applyStimulus();
        applyStimulus();
        checkLiteral("s1 ir_valid", {15'd0, fif.ir_valid}, 16'h0001);
        checkLiteral("s1 ir", fif.ir, 16'h1261);
        checkLiteral("s1 ir_npc", fif.ir_npc, 16'h3001);
        applyStimulus();
        checkLiteral("s1 second addr", fif.mem_addr, 16'h3001);
        repeat (6) applyStimulus();

        // Scenario 2: execute stalled, buffer fills to depth then drains in order
        doReset();
        ackDelay = 0; useFixed = 1'b0;
        repeat (4) applyStimulus();
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkLiteral("s2 no req when full", {15'd0, fif.mem_req}, 16'h0000);
        end
        checkLiteral("s2 head ir", fif.ir, 16'h6A5A);
        checkLiteral("s2 head npc", fif.ir_npc, 16'h3001);
        fif.ir_ready = 1'b1;
        applyStimulus();
        checkLiteral("s2 second ir", fif.ir, 16'h6A5B);
        checkLiteral("s2 second npc", fif.ir_npc, 16'h3002);
        applyStimulus();
        checkLiteral("s2 resume addr", fif.mem_addr, 16'h3002);
        repeat (4) applyStimulus();

        // Scenario 3: redirect while full and idle
        doReset();
        repeat (4) applyStimulus();
        fif.redirect = 1'b1; fif.redirect_pc = 16'h4000;
        applyStimulus();
        fif.redirect = 1'b0;
        checkLiteral("s3 flushed", {15'd0, fif.ir_valid}, 16'h0000);
        applyStimulus();
        checkLiteral("s3 new addr", fif.mem_addr, 16'h4000);
        repeat (3) applyStimulus();

        // Scenario 4: redirect during a slow read, then redirect coinciding with a discarded ack
        doReset();
        ackDelay = 3; fif.ir_ready = 1'b1;
        applyStimulus();
        fif.redirect = 1'b1; fif.redirect_pc = 16'h4000;
        applyStimulus();
        fif.redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkLiteral("s4 held addr", fif.mem_addr, 16'h3000);
            checkLiteral("s4 no ir", {15'd0, fif.ir_valid}, 16'h0000);
            applyStimulus();
        end
        checkLiteral("s4 req dropped", {15'd0, fif.mem_req}, 16'h0000);
        applyStimulus();
        checkLiteral("s4 redirected addr", fif.mem_addr, 16'h4000);
        fif.redirect = 1'b1; fif.redirect_pc = 16'h5000;
        applyStimulus();
        fif.redirect = 1'b0;
        applyStimulus();
        applyStimulus();
        fif.redirect = 1'b1; fif.redirect_pc = 16'h6000;
        applyStimulus();
        fif.redirect = 1'b0;
        checkLiteral("s4 late ack dropped", {15'd0, fif.ir_valid}, 16'h0000);
        applyStimulus();
        checkLiteral("s4 last redirect wins", fif.mem_addr, 16'h6000);
        repeat (6) applyStimulus();

        // Scenario 5: PC wrap at the top of memory
        doReset();
        ackDelay = 0; useFixed = 1'b1; fixedWord = 16'h0E01;
        fif.redirect = 1'b1; fif.redirect_pc = 16'hFFFF;
        applyStimulus();
        fif.redirect = 1'b0;
        applyStimulus();
        checkLiteral("s5 addr ffff", fif.mem_addr, 16'hFFFF);
        applyStimulus();
        checkLiteral("s5 ir", fif.ir, 16'h0E01);
        checkLiteral("s5 ir_npc wraps", fif.ir_npc, 16'h0000);
        applyStimulus();
        checkLiteral("s5 next addr wraps", fif.mem_addr, 16'h0000);
        repeat (3) applyStimulus();

        // Scenario 6: asynchronous reset while a read is outstanding
        doReset();
        ackEnable = 1'b1; ackDelay = 0; useFixed = 1'b0;
        applyStimulus();
        applyStimulus();
        ackEnable = 1'b0;
        applyStimulus();
        checkLiteral("s6 in req", {15'd0, fif.mem_req}, 16'h0001);
        checkLiteral("s6 buffered", {15'd0, fif.ir_valid}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        checkLiteral("s6 req falls", {15'd0, fif.mem_req}, 16'h0000);
        checkLiteral("s6 valid falls", {15'd0, fif.ir_valid}, 16'h0000);
        fif.mem_ack = 1'b0;
        reqAge = 0;
        ackEnable = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus();
        checkLiteral("s6 restart addr", fif.mem_addr, 16'h3000);
        repeat (3) applyStimulus();

        // Mixed traffic: random stalls, latencies and redirects against the model
        doReset();
        for (int i = 0; i < 300; i++) begin
            fif.ir_ready = ($urandom_range(0, 2) != 0);
            ackDelay     = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                fif.redirect    = 1'b1;
                fif.redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            end else begin
                fif.redirect = 1'b0;
            end
            applyStimulus();
        end
        fif.redirect = 1'b0;
        applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
